// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared fetch-stage types and instruction word constants
package cpu_pkg;

    typedef enum logic [1:0] {
        PRIME = 2'd0,
        RUN   = 2'd1,
        HALT  = 2'd2
    } fetch_state_t;

    localparam logic [4:0]  OPC_STP  = 5'b11111;
    localparam logic [15:0] NOP_WORD = 16'h0000;
    localparam logic [15:0] STP_WORD = 16'hF800;

    function automatic logic is_stp(input logic [15:0] word);
        return word[15:11] == OPC_STP;
    endfunction

endpackage

// File: rtl/pc_counter.sv
// rtl/pc_counter.sv - wrapping PC register with sync clear, load, increment and hold
module pc_counter #(
    parameter int AW = 16
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          load,
    input  logic [AW-1:0] load_val,
    input  logic          inc,
    output logic [AW-1:0] q
);

    logic [AW-1:0] q_q;
    logic [AW-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (load) begin
            q_d = load_val;
        end else if (inc) begin
            q_d = q_q + AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - PC ownership, NOP bubble insertion and issue to the decoder
module fetch_sequencer
    import cpu_pkg::*;
#(
    parameter int AW    = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             cnt_en,
    input  logic             pc_sload,
    input  logic [AW-1:0]    new_pc,
    input  logic [15:0]      iq1,
    input  logic [15:0]      iq2,
    output logic [AW-1:0]    pc,
    output logic [15:0]      instr,
    output logic [15:0]      N,
    output logic             running,
    output logic             halted,
    output logic [CNT_W-1:0] retired
);

    fetch_state_t     state_q;
    fetch_state_t     state_d;
    logic [CNT_W-1:0] retired_q;
    logic [CNT_W-1:0] retired_d;
    logic [AW-1:0]    pc_reg;
    logic             pc_ld;
    logic             pc_inc;

    pc_counter #(.AW(AW)) u_pc_counter (
        .clk      (clk),
        .clr      (reset),
        .load     (pc_ld),
        .load_val (new_pc),
        .inc      (pc_inc),
        .q        (pc_reg)
    );

    // Decoder controls only take effect on cycles where a word is actually issued.
    always_comb begin
        state_d   = state_q;
        retired_d = retired_q;
        pc_ld     = 1'b0;
        pc_inc    = 1'b0;
        case (state_q)
            PRIME: begin
                if (!stall) begin
                    pc_ld   = pc_sload;
                    pc_inc  = cnt_en;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!stall) begin
                    pc_ld     = pc_sload;
                    pc_inc    = cnt_en;
                    retired_d = retired_q + CNT_W'(1);
                    if (is_stp(iq1)) begin
                        state_d = HALT;
                    end
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = PRIME;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= PRIME;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
        end
    end

    // A stalled RUN cycle points the decoder back at the suppressed word so it is re-fetched.
    always_comb begin
        instr = NOP_WORD;
        pc    = pc_reg;
        case (state_q)
            RUN: begin
                if (stall) begin
                    pc = pc_reg - AW'(1);
                end else begin
                    instr = iq1;
                end
            end
            HALT:    instr = STP_WORD;
            default: instr = NOP_WORD;
        endcase
    end

    assign N       = iq2;
    assign running = (state_q == RUN);
    assign halted  = (state_q == HALT);
    assign retired = retired_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - scoreboard bench for fetch_sequencer
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        cnt_en;
    logic        pc_sload;
    logic [15:0] new_pc;
    logic [15:0] iq1;
    logic [15:0] iq2;
    logic [15:0] pc;
    logic [15:0] instr;
    logic [15:0] N;
    logic        running;
    logic        halted;
    logic [15:0] retired;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [15:0] pc;
        logic [15:0] instr;
        logic [15:0] n;
        logic        run;
        logic        halt;
        logic [15:0] ret;
    } exp_t;

    exp_t exp_q[$];

    // Reference state: 0 = PRIME, 1 = RUN, 2 = HALT
    int          m_state;
    logic [15:0] m_pc;
    logic [15:0] m_ret;

    fetch_sequencer #(.AW(16), .CNT_W(16)) dut (
        .clk      (clk),
        .reset    (reset),
        .stall    (stall),
        .cnt_en   (cnt_en),
        .pc_sload (pc_sload),
        .new_pc   (new_pc),
        .iq1      (iq1),
        .iq2      (iq2),
        .pc       (pc),
        .instr    (instr),
        .N        (N),
        .running  (running),
        .halted   (halted),
        .retired  (retired)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    task automatic step(input logic rst, input logic st, input logic ce, input logic sl,
                        input logic [15:0] npc, input logic [15:0] i1, input logic [15:0] i2);
        exp_t e;
        reset = rst; stall = st; cnt_en = ce; pc_sload = sl; new_pc = npc; iq1 = i1; iq2 = i2;
        e.n    = i2;
        e.ret  = m_ret;
        e.run  = (m_state == 1);
        e.halt = (m_state == 2);
        e.pc   = m_pc;
        case (m_state)
            0: e.instr = 16'h0000;
            1: begin
                if (st) begin
                    e.instr = 16'h0000;
                    e.pc    = m_pc - 16'd1;
                end else begin
                    e.instr = i1;
                end
            end
            default: e.instr = 16'hF800;
        endcase
        exp_q.push_back(e);

        @(negedge clk);
        e = exp_q.pop_front();
        check("pc", pc, e.pc);
        check("instr", instr, e.instr);
        check("N", N, e.n);
        check("running", running, e.run);
        check("halted", halted, e.halt);
        check("retired", retired, e.ret);

        if (rst) begin
            m_state = 0; m_pc = 16'h0000; m_ret = 16'h0000;
        end else if (m_state != 2 && !st) begin
            if (m_state == 1) begin
                m_ret = m_ret + 16'd1;
                if (i1[15:11] == 5'b11111) m_state = 2;
            end else begin
                m_state = 1;
            end
            if (sl)      m_pc = npc;
            else if (ce) m_pc = m_pc + 16'd1;
        end

        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; stall = 1'b0; cnt_en = 1'b0; pc_sload = 1'b0;
        new_pc = 16'h0000; iq1 = 16'h0000; iq2 = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        m_state = 0; m_pc = 16'h0000; m_ret = 16'h0000;

        // Bubble after reset, then first issue
        step(0, 0, 1, 0, 16'h0000, 16'hABCD, 16'h1111);
        check("t1_pc", pc, 16'h0001);
        check("t1_running", running, 1'b1);
        check("t1_instr", instr, 16'hABCD);

        for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 16'h0000, 16'h1000 + 16'(i), 16'h2000 + 16'(i));
        check("t2_pc", pc, 16'h0005);
        check("t2_retired", retired, 16'd4);

        // Stall three cycles; decoder controls must be ignored
        for (int i = 0; i < 3; i++) step(0, 1, 1, 1, 16'h0033, 16'h4444, 16'h5555);
        step(0, 0, 0, 0, 16'h0000, 16'h0777, 16'h0888);
        check("t4_pc", pc, 16'h0005);
        check("t4_retired", retired, 16'd5);

        step(0, 0, 1, 1, 16'h0041, 16'h0123, 16'h0456);
        check("t3_pc", pc, 16'h0041);

        step(0, 0, 0, 1, 16'hFFFF, 16'h0321, 16'h0000);
        step(0, 0, 1, 0, 16'h0000, 16'h0654, 16'h0000);
        check("t6_wrap", pc, 16'h0000);
        step(0, 1, 0, 0, 16'h0000, 16'h0654, 16'h0000);

        for (int i = 0; i < 40; i++)
            step(0, ($urandom_range(0, 3) == 0), 1'($urandom), ($urandom_range(0, 4) == 0),
                 16'($urandom), 16'($urandom) & 16'hF7FF, 16'($urandom));

        // STP with a simultaneous stall must not halt
        step(0, 1, 1, 0, 16'h0000, 16'hF800, 16'h0000);
        step(0, 0, 1, 0, 16'h0000, 16'hF800, 16'h0000);
        check("t5_halted", halted, 1'b1);
        for (int i = 0; i < 6; i++)
            step(0, 1'(i), 1'(i >> 1), 1'(i + 1), 16'h0010, 16'h0042, 16'h0099);

        step(1, 0, 1, 0, 16'h0000, 16'h0000, 16'h0000);
        step(0, 1, 1, 1, 16'h0099, 16'h0000, 16'h0000);
        step(0, 0, 0, 1, 16'h0020, 16'h0000, 16'h0000);
        step(0, 0, 0, 0, 16'h0000, 16'h0abc, 16'h0000);
        step(1, 0, 1, 0, 16'h0000, 16'h0def, 16'h0000);
        check("t6_rst_pc", pc, 16'h0000);
        check("t6_rst_running", running, 1'b0);
        check("t6_rst_retired", retired, 16'd0);
        check("t6_rst_instr", instr, 16'h0000);
        step(0, 0, 1, 0, 16'h0000, 16'h0bcd, 16'h0000);
        step(0, 0, 1, 0, 16'h0000, 16'h0ace, 16'h0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
